// File: rtl/alu_cmd_sequencer.sv
// Issue stage for a registered 1-cycle ALU: buffers operand/opcode commands in a FIFO,
// issues them one at a time and presents each opcode-tagged result on a valid/ready output.
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   cmd_a,
  input  logic [DATA_WIDTH-1:0]   cmd_b,
  input  logic [2:0]              cmd_op,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [2:0]              alu_op,
  input  logic [2*DATA_WIDTH-1:0] alu_result,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [2*DATA_WIDTH-1:0] res_data,
  output logic [2:0]              res_op,
  output logic                    busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * DATA_WIDTH + 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t                  state;
  logic [EW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic [CW-1:0]           count_next;
  logic                    full_q;
  logic                    empty_q;
  logic                    push;
  logic                    pop;
  logic [DATA_WIDTH-1:0]   head_a;
  logic [DATA_WIDTH-1:0]   head_b;
  logic [2:0]              head_op;

  assign cmd_ready = !full_q;
  assign busy      = (state != S_IDLE) || !empty_q;
  assign push      = cmd_valid && !full_q;
  // The FIFO is only popped at the moment a command is loaded into the ALU registers.
  assign pop       = !empty_q &&
                     ((state == S_IDLE) || (state == S_OUT && res_valid && res_ready));
  assign {head_op, head_a, head_b} = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (!push && pop)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      state     <= S_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count   <= count_next;
      full_q  <= (count_next == CW'(FIFO_DEPTH));
      empty_q <= (count_next == '0);

      case (state)
        S_IDLE: begin
          if (!empty_q) begin
            alu_a  <= head_a;
            alu_b  <= head_b;
            alu_op <= head_op;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          res_data  <= alu_result;
          res_op    <= alu_op;
          res_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            if (!empty_q) begin
              alu_a  <= head_a;
              alu_b  <= head_b;
              alu_op <= head_op;
              state  <= S_ISSUE;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural registered ALU attached.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_result = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic [2:0]  res_op;
  logic        busy;

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  op;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          xfer_cyc[$];
  logic [15:0] cur_exp = '0;
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;

  alu_cmd_sequencer #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural ALU: samples operands on each edge, result valid one cycle later.
  always @(posedge clk) begin
    case (alu_op)
      3'd0: alu_result <= {8'h00, alu_a} + {8'h00, alu_b};
      3'd1: alu_result <= {8'h00, alu_a} - {8'h00, alu_b};
      3'd2: alu_result <= {8'h00, alu_a ^ alu_b};
      3'd3: alu_result <= {8'h00, alu_a & alu_b};
      3'd4: alu_result <= {8'h00, alu_a | alu_b};
      3'd5: alu_result <= alu_a * alu_b;
      3'd6: alu_result <= {alu_a, alu_b};
      default: alu_result <= {alu_b, alu_a};
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready)
      sb.push_back('{d: cur_exp, op: cmd_op});
  end

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_result: got data %0h op %0d expected no result", res_data, res_op);
      end else begin
        mon_e = sb.pop_front();
        check("res_data", 32'(res_data), 32'(mon_e.d));
        check("res_op", 32'(res_op), 32'(mon_e.op));
      end
      xfer_cyc.push_back(cyc);
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [15:0] exp);
    int n = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cur_exp = exp; cmd_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        $display("FAIL send_timeout: got cmd_ready 0 expected 1 within 50 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      $display("FAIL %s_timeout: got res_valid 0 expected 1", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_res_data", 32'(res_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: single ADD, latency of three edges
    res_ready = 1'b1;
    send(8'hFF, 8'h01, 3'd0, 16'h0100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_latency", 32'(res_valid), (i == 3) ? 32'd1 : 32'd0);
    end
    wait_idle("t1");

    // 2: assorted opcodes, back-to-back
    send(8'hFF, 8'hFF, 3'd5, 16'hFE01);
    send(8'hA5, 8'h0F, 3'd2, 16'h00AA);
    send(8'h10, 8'h20, 3'd1, 16'hFFF0);
    send(8'hF0, 8'h3C, 3'd3, 16'h0030);
    send(8'hF0, 8'h0F, 3'd4, 16'h00FF);
    send(8'h12, 8'h34, 3'd6, 16'h1234);
    send(8'h12, 8'h34, 3'd7, 16'h3412);
    wait_idle("t2");

    // 3: fill under backpressure, then drain at full rate
    res_ready = 1'b0;
    xfer_cyc.delete();
    send(8'h01, 8'h02, 3'd0, 16'h0003);
    send(8'h03, 8'h04, 3'd5, 16'h000C);
    send(8'h10, 8'h20, 3'd1, 16'hFFF0);
    send(8'hF0, 8'h3C, 3'd3, 16'h0030);
    send(8'hF0, 8'h0F, 3'd4, 16'h00FF);
    @(negedge clk);
    check("t3_full", 32'(cmd_ready), 0);
    check("t3_busy", 32'(busy), 1);
    @(posedge clk); #1;
    cmd_a = 8'hEE; cmd_b = 8'hEE; cmd_op = 3'd0; cur_exp = 16'hDEAD; cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle("t3");
    check("t3_count", 32'(xfer_cyc.size()), 5);
    if (xfer_cyc.size() == 5)
      for (int i = 1; i < 5; i++)
        check("t3_interval", 32'(xfer_cyc[i] - xfer_cyc[i-1]), 3);

    // 4: long hold with a second command queued
    res_ready = 1'b0;
    send(8'h12, 8'h34, 3'd6, 16'h1234);
    send(8'h56, 8'h78, 3'd7, 16'h7856);
    wait_valid("t4");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_res_data", 32'(res_data), 32'h1234);
      check("t4_res_op", 32'(res_op), 6);
      check("t4_alu_a", 32'(alu_a), 32'h12);
      check("t4_alu_op", 32'(alu_op), 6);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_idle("t4");

    // 5: reset during WAIT with three commands queued
    res_ready = 1'b0;
    send(8'h01, 8'h01, 3'd0, 16'h0002);
    wait_valid("t5");
    send(8'h02, 8'h02, 3'd0, 16'h0004);
    send(8'h03, 8'h03, 3'd0, 16'h0006);
    send(8'h04, 8'h04, 3'd0, 16'h0008);
    cmd_a = 8'h05; cmd_b = 8'h05; cmd_op = 3'd0; cur_exp = 16'h000A; cmd_valid = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; res_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("t5_res_valid", 32'(res_valid), 0);
    check("t5_cmd_ready", 32'(cmd_ready), 1);
    check("t5_busy", 32'(busy), 0);
    check("t5_alu_a", 32'(alu_a), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    repeat (30) @(negedge clk);
    check("t5_idle_after", 32'(busy), 0);
    @(posedge clk); #1;

    // 6: push on the same edge as an OUT->ISSUE pop with two queued
    res_ready = 1'b0;
    send(8'h11, 8'h11, 3'd0, 16'h0022);
    send(8'h22, 8'h22, 3'd0, 16'h0044);
    send(8'h33, 8'h33, 3'd0, 16'h0066);
    wait_valid("t6");
    @(posedge clk); #1;
    cmd_a = 8'h44; cmd_b = 8'h44; cmd_op = 3'd0; cur_exp = 16'h0088; cmd_valid = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    check("t6_ready_after_swap", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    send(8'h55, 8'h55, 3'd0, 16'h00AA);
    send(8'h66, 8'h66, 3'd0, 16'h00CC);
    @(negedge clk);
    check("t6_full_after_2", 32'(cmd_ready), 0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_idle("t6");

    check("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
